psg_register_bus: RTL

PSG_REGISTER_BUS -- requirements
Module: psg_register_bus

---
 rtl/psg_register_bus.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/psg_register_bus.sv
// PSG-style register file behind an asynchronous BDIR/BC1 bus: synchronizes the
// bus, latches an address, commits writes into R0-R15 and serves registered reads.
module psg_register_bus (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bdir,
  input  logic        bc1,
  input  logic        a8,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic [11:0] tone_period_a,
  output logic [11:0] tone_period_b,
  output logic [11:0] tone_period_c,
  output logic [4:0]  noise_period,
  output logic [7:0]  mixer,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] envelope_period,
  output logic [3:0]  envelope_shape,
  output logic        env_restart
);

  // State encoding equals the bus mode {bdir,bc1}, so the next state is the mode itself.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    LATCH = 2'b11
  } state_e;

  logic [10:0] sync1_q, sync2_q;
  logic [1:0]  mode_s;
  logic        a8_s;
  logic [7:0]  data_s;

  state_e      state_q, state_d;
  logic        leave_latch;
  logic        commit;

  logic [7:0]  cap_data_q;
  logic        cap_a8_q;
  logic [7:0]  wdata_q;
  logic [3:0]  addr_q;
  logic        addr_valid_q;
  logic [7:0]  regs_q [16];
  logic        env_restart_q;
  logic [7:0]  dout_q;
  logic        doe_q;

  // Drops the bits of a register that the sound generator does not implement.
  function automatic logic [7:0] mask_byte(input logic [3:0] r, input logic [7:0] d);
    case (r)
      4'd1, 4'd3, 4'd5, 4'd13: return d & 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: return d & 8'h1F;
      default:                 return d;
    endcase
  endfunction

  assign mode_s = sync2_q[10:9];
  assign a8_s   = sync2_q[8];
  assign data_s = sync2_q[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make the two stages a real shift, not one wire.
      sync1_q <= {bdir, bc1, a8, data_in};
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a value up front, so no latch is inferred.
    state_d     = state_e'(mode_s);
    leave_latch = 1'b0;
    commit      = 1'b0;
    if (state_q == LATCH && state_d != LATCH) leave_latch = 1'b1;
    if (state_q == WRITE && state_d != WRITE) commit = addr_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data_q   <= '0;
      cap_a8_q     <= 1'b0;
      wdata_q      <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      if (state_d == LATCH) begin
        cap_data_q <= data_s;
        cap_a8_q   <= a8_s;
      end
      if (state_d == WRITE) wdata_q <= data_s;
      if (leave_latch) begin
        addr_q       <= cap_data_q[3:0];
        addr_valid_q <= (cap_data_q[7:4] == 4'h0) && cap_a8_q;
      end
    end
  end

  // Commit uses the address held before this edge, so WRITE->LATCH writes the old register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the register file must read as zero after reset, so every entry is cleared.
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      env_restart_q <= 1'b0;
    end else begin
      if (commit) regs_q[addr_q] <= mask_byte(addr_q, wdata_q);
      env_restart_q <= commit && (addr_q == 4'd13);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      doe_q  <= 1'b0;
    end else if (state_q == READ && addr_valid_q) begin
      dout_q <= regs_q[addr_q];
      doe_q  <= 1'b1;
    end else begin
      dout_q <= '0;
      doe_q  <= 1'b0;
    end
  end

  assign data_out        = dout_q;
  assign data_oe         = doe_q;
  assign tone_period_a   = {regs_q[1][3:0], regs_q[0]};
  assign tone_period_b   = {regs_q[3][3:0], regs_q[2]};
  assign tone_period_c   = {regs_q[5][3:0], regs_q[4]};
  assign noise_period    = regs_q[6][4:0];
  assign mixer           = regs_q[7];
  assign amp_a           = regs_q[8][4:0];
  assign amp_b           = regs_q[9][4:0];
  assign amp_c           = regs_q[10][4:0];
  assign envelope_period = {regs_q[12], regs_q[11]};
  assign envelope_shape  = regs_q[13][3:0];
  assign env_restart     = env_restart_q;

endmodule
